// File: rtl/frame_packer.sv
// -----------------------------------------------------------------------------
// frame_packer
//
// Wraps each upstream frame into a host-link packet:
//   header word 0 : {SYNC_WORD, len}
//   header word 1 : frame counter (value before this packet is counted)
//   [header word 2: latched cycle timestamp, FRAME_PACKER_TIMESTAMP_EN only]
//   payload       : len words from upstream. If upstream stalls for TIMEOUT
//                   cycles, the rest of the frame is filled with PAD_WORD.
//   trailer       : 32-bit wrapping sum of payload and pad words
//
// Optional build macro: FRAME_PACKER_TIMESTAMP_EN adds the timestamp header
// word. That word is not included in the checksum.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_frame_start     one-cycle start pulse; i_frame_len is sampled with it
//   i_in_data/valid   upstream payload stream, o_in_ready back-pressure
//   o_out_data/valid  packet stream, i_out_ready from downstream
//   o_busy            high from the accepted start until the trailer beat
//   o_err_timeout     sticky: a frame was padded
//   o_err_overrun     sticky: a start pulse arrived while busy
//   o_frame_cnt       number of completed packets (wraps)
// -----------------------------------------------------------------------------
module frame_packer #(
    parameter logic [15:0] SYNC_WORD = 16'hA55A,
    parameter int unsigned TIMEOUT   = 1024,
    parameter logic [31:0] PAD_WORD  = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_frame_start,
    input  logic [15:0] i_frame_len,
    input  logic [31:0] i_in_data,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    output logic [31:0] o_out_data,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic        o_busy,
    output logic        o_err_timeout,
    output logic        o_err_overrun,
    output logic [31:0] o_frame_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR0    = 3'd1;
    localparam logic [2:0] S_HDR1    = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd4;
    localparam logic [2:0] S_TRAIL   = 3'd5;
`ifdef FRAME_PACKER_TIMESTAMP_EN
    localparam logic [2:0] S_TS      = 3'd3;
`endif

    logic [2:0]    state;
    logic [15:0]   remaining;   // payload words still to be loaded
    logic [31:0]   checksum;
    logic [TW-1:0] to_cnt;
    logic          pad_mode;    // timeout hit: fill the rest of the frame

    logic slot_free;
    logic beat;
    logic accept;

`ifdef FRAME_PACKER_TIMESTAMP_EN
    logic [31:0] cycle_cnt;
    logic [31:0] ts_latch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

    // The output register can take a new word when it is empty or its current
    // word leaves on this edge.
    assign slot_free = ~o_out_valid | i_out_ready;
    assign beat      = o_out_valid & i_out_ready;

    // Never accept more than the announced length, and stop listening once the
    // frame has switched to padding.
    assign o_in_ready = (state == S_PAYLOAD) && !pad_mode &&
                        (remaining != 16'd0) && slot_free;
    assign accept     = i_in_valid & o_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            remaining     <= '0;
            checksum      <= '0;
            to_cnt        <= '0;
            pad_mode      <= 1'b0;
            o_out_data    <= '0;
            o_out_valid   <= 1'b0;
            o_busy        <= 1'b0;
            o_err_timeout <= 1'b0;
            o_err_overrun <= 1'b0;
            o_frame_cnt   <= '0;
`ifdef FRAME_PACKER_TIMESTAMP_EN
            ts_latch      <= '0;
`endif
        end else begin
            if (i_frame_start && state != S_IDLE) begin
                o_err_overrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (i_frame_start) begin
                        // Header word 0 is loaded directly so it is presented
                        // in the first HDR0 cycle.
                        remaining   <= i_frame_len;
                        to_cnt      <= '0;
                        pad_mode    <= 1'b0;
                        o_out_data  <= {SYNC_WORD, i_frame_len};
                        o_out_valid <= 1'b1;
                        o_busy      <= 1'b1;
                        state       <= S_HDR0;
`ifdef FRAME_PACKER_TIMESTAMP_EN
                        ts_latch    <= cycle_cnt;
`endif
                    end
                end

                S_HDR0: begin
                    if (beat) begin
                        o_out_data <= o_frame_cnt;
                        state      <= S_HDR1;
                    end
                end

                S_HDR1: begin
                    if (beat) begin
`ifdef FRAME_PACKER_TIMESTAMP_EN
                        o_out_data <= ts_latch;
                        state      <= S_TS;
`else
                        if (remaining != 16'd0) begin
                            o_out_valid <= 1'b0;
                            state       <= S_PAYLOAD;
                        end else begin
                            o_out_data <= checksum;
                            state      <= S_TRAIL;
                        end
`endif
                    end
                end

`ifdef FRAME_PACKER_TIMESTAMP_EN
                S_TS: begin
                    if (beat) begin
                        if (remaining != 16'd0) begin
                            o_out_valid <= 1'b0;
                            state       <= S_PAYLOAD;
                        end else begin
                            o_out_data <= checksum;
                            state      <= S_TRAIL;
                        end
                    end
                end
`endif

                S_PAYLOAD: begin
                    if (remaining == 16'd0) begin
                        // All words loaded; the trailer follows the last
                        // payload word as soon as the register frees up.
                        if (slot_free) begin
                            o_out_data  <= checksum;
                            o_out_valid <= 1'b1;
                            state       <= S_TRAIL;
                        end
                    end else if (pad_mode) begin
                        if (slot_free) begin
                            o_out_data  <= PAD_WORD;
                            o_out_valid <= 1'b1;
                            checksum    <= checksum + PAD_WORD;
                            remaining   <= remaining - 16'd1;
                        end
                    end else if (accept) begin
                        o_out_data  <= i_in_data;
                        o_out_valid <= 1'b1;
                        checksum    <= checksum + i_in_data;
                        remaining   <= remaining - 16'd1;
                        to_cnt      <= '0;
                    end else begin
                        if (beat) begin
                            o_out_valid <= 1'b0;
                        end
                        to_cnt <= to_cnt + TW'(1);
                        if (to_cnt == TW'(TIMEOUT - 1)) begin
                            pad_mode      <= 1'b1;
                            o_err_timeout <= 1'b1;
                        end
                    end
                end

                S_TRAIL: begin
                    if (beat) begin
                        o_out_valid <= 1'b0;
                        o_frame_cnt <= o_frame_cnt + 32'd1;
                        checksum    <= '0;
                        o_busy      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_packer.sv
// -----------------------------------------------------------------------------
// tb_frame_packer: directed tests for frame_packer with hand-computed packets.
// TIMEOUT is reduced to 16 to keep the padding test short.
// -----------------------------------------------------------------------------
module tb_frame_packer;

    logic        clk;
    logic        rst;
    logic        frame_start;
    logic [15:0] frame_len;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        err_timeout;
    logic        err_overrun;
    logic [31:0] frame_cnt;

    frame_packer #(
        .SYNC_WORD (16'hA55A),
        .TIMEOUT   (16),
        .PAD_WORD  (32'hDEADBEEF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_frame_start (frame_start),
        .i_frame_len   (frame_len),
        .i_in_data     (in_data),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .o_out_data    (out_data),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_busy        (busy),
        .o_err_timeout (err_timeout),
        .o_err_overrun (err_overrun),
        .o_frame_cnt   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] src_q[$];
    logic        src_en    = 1'b0;
    logic        toggle    = 1'b0;
    logic        acc_s     = 1'b0;
    logic        saw_ready = 1'b0;
    int          stall_viol = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Monitor: everything sampled on the falling edge.
    always @(negedge clk) begin
        if (out_valid && out_ready) got_q.push_back(out_data);
        if (prev_stall && out_data !== prev_data) stall_viol++;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        acc_s      = in_valid && in_ready;
        if (in_ready) saw_ready = 1'b1;
    end

    // Upstream source and downstream ready driver.
    always @(posedge clk) begin
        #1;
        if (acc_s && src_q.size() != 0) void'(src_q.pop_front());
        in_valid  = src_en && (src_q.size() != 0);
        in_data   = (src_q.size() != 0) ? src_q[0] : 32'd0;
        out_ready = toggle ? ~out_ready : 1'b1;
    end

    task automatic do_start(input logic [15:0] len);
        @(posedge clk); #1;
        frame_start = 1'b1;
        frame_len   = len;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check({tag, "_done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_pkt(input string tag);
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_w%0d", tag, i),
                  (i < got_q.size()) ? got_q[i] : 32'hXXXXXXXX, exp_q[i]);
        end
        $display("packet %s: %0d words received, %0d expected", tag, got_q.size(), exp_q.size());
        got_q.delete();
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; frame_len = '0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cnt", frame_cnt, 32'd0);
        check("rst_inrdy", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // 1: basic len=4 packet
        src_q = '{32'd1, 32'd2, 32'd3, 32'd4}; src_en = 1'b1;
        do_start(16'd4);
        check("t1_busy_hi", {31'd0, busy}, 32'd1);
        wait_idle("t1");
        exp_q = '{32'hA55A0004, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'h0000000A};
        check_pkt("t1");
        check("t1_cnt", frame_cnt, 32'd1);

        // 2: empty frame, upstream never asked for data
        saw_ready = 1'b0; src_q.delete();
        do_start(16'd0);
        wait_idle("t2");
        exp_q = '{32'hA55A0000, 32'd1, 32'd0};
        check_pkt("t2");
        check("t2_no_inrdy", {31'd0, saw_ready}, 32'd0);

        // 3: downstream back-pressure every other cycle
        src_q = '{32'd5, 32'd6, 32'd7}; stall_viol = 0; toggle = 1'b1;
        do_start(16'd3);
        wait_idle("t3");
        toggle = 1'b0;
        exp_q = '{32'hA55A0003, 32'd2, 32'd5, 32'd6, 32'd7, 32'h00000012};
        check_pkt("t3");
        check("t3_stable", stall_viol, 32'd0);
        check("t3_no_to", {31'd0, err_timeout}, 32'd0);

        // 4: upstream starves after one word -> padding
        src_q = '{32'h00000010};
        do_start(16'd3);
        wait_idle("t4");
        exp_q = '{32'hA55A0003, 32'd3, 32'h00000010, 32'hDEADBEEF, 32'hDEADBEEF, 32'hBD5B7DEE};
        check_pkt("t4");
        check("t4_to", {31'd0, err_timeout}, 32'd1);
        check("t4_no_ovr", {31'd0, err_overrun}, 32'd0);

        // 5: second start during PAYLOAD is an overrun and ignored
        src_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        src_en = 1'b0;
        do_start(16'd8);
        repeat (3) @(posedge clk);
        do_start(16'd2);
        src_en = 1'b1;
        wait_idle("t5");
        repeat (6) @(negedge clk);
        exp_q = '{32'hA55A0008, 32'd4, 32'd1, 32'd2, 32'd3, 32'd4,
                  32'd5, 32'd6, 32'd7, 32'd8, 32'h00000024};
        check_pkt("t5");
        check("t5_ovr", {31'd0, err_overrun}, 32'd1);
        check("t5_to_sticky", {31'd0, err_timeout}, 32'd1);
        check("t5_idle", {31'd0, busy}, 32'd0);
        check("t5_cnt", frame_cnt, 32'd5);

        // 6: asynchronous reset mid-payload, then a clean frame
        src_q = '{32'd9, 32'd9, 32'd9, 32'd9}; src_en = 1'b0;
        do_start(16'd4);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("t6_valid", {31'd0, out_valid}, 32'd0);
        check("t6_data", out_data, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_cnt", frame_cnt, 32'd0);
        check("t6_to", {31'd0, err_timeout}, 32'd0);
        check("t6_ovr", {31'd0, err_overrun}, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        got_q.delete();
        src_q = '{32'h00000055}; src_en = 1'b1;
        do_start(16'd1);
        wait_idle("t6b");
        exp_q = '{32'hA55A0001, 32'd0, 32'h00000055, 32'h00000055};
        check_pkt("t6b");
        check("t6b_cnt", frame_cnt, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
